// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_unit
// Purpose  : Iterative WIDTHxWIDTH multiply / multiply-accumulate unit for the
//            EX stage. Owns the architectural HI/LO registers and runs a
//            radix-2 shift-add engine (one multiplier bit per cycle), holding
//            the pipeline through a stall request while it works.
// Ports    : clk     - pipeline clock, all state changes on rising edge
//            rst     - synchronous active-high reset
//            start   - qualifies mul_op/op_a/op_b this cycle
//            mul_op  - 000 MULT, 001 MULTU, 010 MADD, 011 MSUB,
//                      100 MTHI, 101 MTLO, 11x no-op
//            op_a    - rs operand (multiplicand, MTHI/MTLO source)
//            op_b    - rt operand (multiplier)
//            flush   - abort in-flight op, HI/LO untouched
//            hi, lo  - architectural HI/LO registers
//            busy    - unit is not idle
//            stall   - pipeline hold request (same as busy)
//            done    - one-cycle pulse after a multiply result lands in HI/LO
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mul_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic [WIDTH-1:0]       mcand;
    logic [WIDTH-1:0]       mplier;
    logic [2*WIDTH-1:0]     prod;
    logic                   neg;
    logic [1:0]             op_sel;

    // Request decode: flush always beats start in IDLE.
    logic                   req_ok;
    logic                   mul_start;
    logic                   is_signed_op;
    logic [WIDTH-1:0]       mag_a;
    logic [WIDTH-1:0]       mag_b;
    logic [WIDTH:0]         add_sum;
    logic [2*WIDTH-1:0]     prod_fixed;
    logic [2*WIDTH-1:0]     acc_nxt;

    assign req_ok       = start && !flush;
    assign mul_start    = req_ok && !mul_op[2];
    assign is_signed_op = (mul_op != OP_MULTU);

    // Magnitudes for the unsigned engine. The most negative value negates to
    // itself, which is exactly its magnitude when read as unsigned.
    assign mag_a = (is_signed_op && op_a[WIDTH-1]) ? -op_a : op_a;
    assign mag_b = (is_signed_op && op_b[WIDTH-1]) ? -op_b : op_b;

    // One shift-add step: the (WIDTH+1)-bit sum keeps the carry, which is
    // shifted back into the top of the product.
    assign add_sum = {1'b0, prod[2*WIDTH-1:WIDTH]}
                   + {1'b0, mcand & {WIDTH{mplier[0]}}};

    assign prod_fixed = neg ? -prod : prod;

    always_comb begin
        acc_nxt = prod_fixed;
        case (op_sel)
            2'b10:   acc_nxt = {hi, lo} + prod_fixed;
            2'b11:   acc_nxt = {hi, lo} - prod_fixed;
            default: acc_nxt = prod_fixed;
        endcase
    end

    // Next-state and status outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (mul_start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = FIX;
                end
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign stall = busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            neg    <= 1'b0;
            op_sel <= 2'b00;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (mul_start) begin
                        mcand  <= mag_a;
                        mplier <= mag_b;
                        prod   <= '0;
                        cnt    <= '0;
                        neg    <= is_signed_op && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        op_sel <= mul_op[1:0];
                    end else if (req_ok && (mul_op == OP_MTHI)) begin
                        hi <= op_a;
                    end else if (req_ok && (mul_op == OP_MTLO)) begin
                        lo <= op_a;
                    end
                end
                RUN: begin
                    if (!flush) begin
                        prod   <= {add_sum, prod[WIDTH-1:1]};
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CNT_W'(1);
                    end
                end
                FIX: begin
                    if (!flush) begin
                        {hi, lo} <= acc_nxt;
                        done     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
